mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multicycle control sequencer for the MIPS datapath (register file, ALU with zero `flag`, PC, instruction register).
- Decodes `INST` and steps the datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives every mux select and write enable.
- Arbitrates the single shared memory port between instruction fetch and data access through a req/ack handshake with timeout.

Parameters:
- ACK_TIMEOUT, 16: max cycles a memory state waits for mem_ack before bus error (≥1).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-low reset.
- INST  in  32  instruction register contents (datapath IR output).
- flag  in  1  ALU zero flag.
- mem_ack  in  1  memory completion for the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  1=store, 0=load/fetch; valid with mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_we  out  1  IR write enable.
- pc_we  out  1  PC write enable (unconditional or branch-qualified).
- pc_src  out  2  00=ALU result, 01=ALU out register (branch target), 10=jump target {PC[31:28],INST[25:0],2'b00}.
- reg_we  out  1  register-file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALU out register, 1=memory data register.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- state  out  4  current state code (debug).
- illegal  out  1  sticky: unsupported opcode/funct seen.
- bus_err  out  1  sticky: ack timeout occurred.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=FETCH(0).
  - illegal=0, bus_err=0, retired=0, timeout counter=0.
  - While RST=0, all control outputs (mem_req, ir_we, pc_we, reg_we, mem_we) are forced 0.
  - Reset mid-operation abandons any outstanding request with no completion side-effects.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12. Codes 13–15 go to HALT.
- Outputs are Moore decodes of state, except ir_we/pc_we in FETCH and pc_we in BRANCH. Unlisted outputs are 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - On mem_ack=1: ir_we=1, pc_we=1, go to DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD. Next state by opcode INST[31:26]:
  - 100011/101011 → MEMADR.
  - 000000 → EXEC.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Else set illegal and go to FETCH (instruction skipped, not retired).
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, iord=1. On ack → MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. On ack → FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_op from funct INST[5:0]: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Other funct: set illegal, go to FETCH.
- RWB: reg_we=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=flag → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD → ADDIWB.
- ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_src=10, pc_we=1 → FETCH.
- Handshake:
  - mem_req is held high until mem_ack is sampled high. Ack in the first req cycle is legal (zero wait).
  - mem_ack with mem_req=0 is ignored.
  - One request is outstanding at most. Data and fetch never overlap.
- Timeout:
  - The counter clears on entry to each memory state and increments each cycle without ack.
  - When it reaches ACK_TIMEOUT without ack: set bus_err, go to HALT.
  - An ack in the same cycle the counter hits ACK_TIMEOUT counts as success.
- HALT: all enables 0; exit only by reset.
- retired:
  - Increments by 1 on exit from MEMWB, MEMWR (ack), RWB, BRANCH (taken or not), ADDIWB, JUMP.
  - Wraps modulo 2^CNT_W.
- Latency, zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.

Test Plan:
- Reset then `add $3,$1,$2` (0x00221820), ack every req:
  - states 0,1,6,7.
  - reg_we=1 and reg_dst=1 in cycle 4.
  - retired=1.
- `lw $8,4($0)` (0x8C080004), ack delayed 3 cycles in MEMRD:
  - MEMRD held 4 cycles with mem_req=1, iord=1.
  - MEMWB has mem_to_reg=1.
  - 8 cycles total.
- `beq` (0x10220003), flag=1 then flag=0 runs:
  - pc_we=1 with pc_src=01 only when flag=1.
  - Both runs: retired +1, 3 cycles.
- Opcode 0x3F and R-type funct 0x3F:
  - illegal sets and stays set.
  - Return to FETCH; retired unchanged.
- ACK_TIMEOUT=16, never ack in FETCH:
  - bus_err=1 after 16 cycles; state=12.
  - mem_req=0 thereafter.
  - RST=0 for one edge restores FETCH with bus_err=0.
- RST low during MEMWR wait: next state FETCH, retired unchanged, mem_we=0 while RST=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle control sequencer for a MIPS datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// drives every datapath mux select and write enable, and owns the single
// shared memory port through a req/ack handshake guarded by a timeout.
module mips_mc_ctrl #(
  parameter int ACK_TIMEOUT = 16,  // max wait cycles for mem_ack (>= 1)
  parameter int CNT_W       = 32   // retired-instruction counter width
) (
  input  logic             CLK,
  input  logic             RST,         // synchronous, active-low
  input  logic [31:0]      INST,        // instruction register contents
  input  logic             flag,        // ALU zero flag
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  // Opcodes (INST[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (INST[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_ALUO = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // The wait counter only ever has to hold 0 .. ACK_TIMEOUT-1.
  localparam int TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       in_mem_state;
  logic       to_last;
  logic       retire;
  logic       unused_inst_bits;

  assign opcode = INST[31:26];
  assign funct  = INST[5:0];

  // Register fields and the jump/immediate fields are consumed by the datapath.
  assign unused_inst_bits = ^INST[25:6];

  // The memory port is only ever requested from these three states, so at
  // most one request is outstanding and fetch/data accesses never overlap.
  assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                        (state_q == ST_MEMWR);

  // Final permitted wait cycle: an ack here still succeeds.
  assign to_last = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

  // Decode the R-type function field into an ALU operation.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state, sticky-flag, timeout and retirement logic.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default: begin
            // Unsupported opcode: skip it without retiring.
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        if (mem_ack) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (funct_ok) begin
          state_d = ST_RWB;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_RWB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDIEX: begin
        state_d = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unused codes 13-15 park the sequencer.
        state_d = ST_HALT;
      end
    endcase

    // Waiting for ack: count the cycle, or give up on the last one.
    // Every other case leaves the counter cleared for the next memory state.
    if (in_mem_state && !mem_ack) begin
      if (to_last) begin
        bus_err_d = 1'b1;
        state_d   = ST_HALT;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_FETCH;
      to_cnt_q  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  // Moore decode of control outputs; only FETCH (ir_we/pc_we on ack) and
  // BRANCH (pc_we on flag) look at inputs. Enables are masked in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_AND;

    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_src    = PCSRC_ALU;
        ir_we     = mem_ack;
        pc_we     = mem_ack;
      end
      ST_DECODE: begin
        alu_src_a = 1'b0;
        alu_src_b = SRCB_IMMSH2;
        alu_op    = ALU_ADD;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEMWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = funct_alu;
      end
      ST_RWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUO;
        pc_we     = flag;
      end
      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_ADDIWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
      end
      ST_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_we  = 1'b1;
      end
      default: begin
        // HALT and unused codes: everything stays inactive.
      end
    endcase

    if (!RST) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for the multicycle MIPS control sequencer.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [31:0]      INST = 32'h0;
  logic             flag = 1'b0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]       pc_src;
  logic             reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic [3:0]       state;
  logic             illegal, bus_err;
  logic [CNT_W-1:0] retired;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  mips_mc_ctrl #(.ACK_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .INST(INST), .flag(flag), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal(illegal), .bus_err(bus_err),
    .retired(retired)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then check the state.
  task automatic cyc(input logic rst, input logic ack, input logic fl,
                     input logic [3:0] st, input string tag);
    @(negedge CLK);
    RST     = rst;
    mem_ack = ack;
    flag    = fl;
    #1;
    check_val({tag, ".state"}, state, st);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge CLK);
    #1;
    check_val("rst.state",   state,   4'd0);
    check_val("rst.mem_req", mem_req, 1'b0);
    check_val("rst.illegal", illegal, 1'b0);
    check_val("rst.bus_err", bus_err, 1'b0);
    check_val("rst.retired", retired, 0);

    // ---------------- add $3,$1,$2 ----------------
    INST = 32'h00221820;
    cyc(1, 1, 0, 4'd0, "add.fetch");
    check_val("add.fetch.mem_req", mem_req, 1'b1);
    check_val("add.fetch.ir_we", ir_we, 1'b1);
    check_val("add.fetch.pc_we", pc_we, 1'b1);
    check_val("add.fetch.iord", iord, 1'b0);
    check_val("add.fetch.srcb", alu_src_b, 2'b01);
    check_val("add.fetch.aluop", alu_op, 4'b0010);
    cyc(1, 1, 0, 4'd1, "add.decode");
    check_val("add.decode.srcb", alu_src_b, 2'b11);
    check_val("add.decode.mem_req", mem_req, 1'b0);
    cyc(1, 1, 0, 4'd6, "add.exec");
    check_val("add.exec.srca", alu_src_a, 1'b1);
    check_val("add.exec.srcb", alu_src_b, 2'b00);
    check_val("add.exec.aluop", alu_op, 4'b0010);
    cyc(1, 1, 0, 4'd7, "add.rwb");
    check_val("add.rwb.reg_we", reg_we, 1'b1);
    check_val("add.rwb.reg_dst", reg_dst, 1'b1);
    check_val("add.rwb.m2r", mem_to_reg, 1'b0);
    $display("txn add done");

    // ---------------- lw $8,4($0), ack after 3 waits ----------------
    cyc(1, 1, 0, 4'd0, "lw.fetch");
    INST = 32'h8C080004;
    check_val("lw.fetch.retired", retired, 1);
    cyc(1, 0, 0, 4'd1, "lw.decode");
    cyc(1, 0, 0, 4'd2, "lw.memadr");
    check_val("lw.memadr.srca", alu_src_a, 1'b1);
    check_val("lw.memadr.srcb", alu_src_b, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 4'd3, "lw.memrd_wait");
      check_val("lw.memrd_wait.mem_req", mem_req, 1'b1);
      check_val("lw.memrd_wait.iord", iord, 1'b1);
    end
    cyc(1, 1, 0, 4'd3, "lw.memrd_ack");
    check_val("lw.memrd_ack.mem_req", mem_req, 1'b1);
    check_val("lw.memrd_ack.mem_we", mem_we, 1'b0);
    cyc(1, 0, 0, 4'd4, "lw.memwb");
    check_val("lw.memwb.reg_we", reg_we, 1'b1);
    check_val("lw.memwb.m2r", mem_to_reg, 1'b1);
    check_val("lw.memwb.reg_dst", reg_dst, 1'b0);
    $display("txn lw done");

    // ---------------- sw $8,4($0) ----------------
    cyc(1, 1, 0, 4'd0, "sw.fetch");
    INST = 32'hAC080004;
    check_val("sw.fetch.retired", retired, 2);
    cyc(1, 0, 0, 4'd1, "sw.decode");
    cyc(1, 0, 0, 4'd2, "sw.memadr");
    cyc(1, 1, 0, 4'd5, "sw.memwr");
    check_val("sw.memwr.mem_we", mem_we, 1'b1);
    check_val("sw.memwr.mem_req", mem_req, 1'b1);
    check_val("sw.memwr.iord", iord, 1'b1);
    $display("txn sw done");

    // ---------------- beq taken ----------------
    cyc(1, 1, 0, 4'd0, "beq1.fetch");
    INST = 32'h10220003;
    check_val("beq1.fetch.retired", retired, 3);
    cyc(1, 0, 1, 4'd1, "beq1.decode");
    cyc(1, 0, 1, 4'd8, "beq1.branch");
    check_val("beq1.branch.pc_we", pc_we, 1'b1);
    check_val("beq1.branch.pc_src", pc_src, 2'b01);
    check_val("beq1.branch.aluop", alu_op, 4'b0110);
    $display("txn beq taken done");

    // ---------------- beq not taken ----------------
    cyc(1, 1, 0, 4'd0, "beq0.fetch");
    check_val("beq0.fetch.retired", retired, 4);
    cyc(1, 0, 0, 4'd1, "beq0.decode");
    cyc(1, 0, 0, 4'd8, "beq0.branch");
    check_val("beq0.branch.pc_we", pc_we, 1'b0);
    $display("txn beq not-taken done");

    // ---------------- j ----------------
    cyc(1, 1, 0, 4'd0, "j.fetch");
    INST = 32'h08000010;
    check_val("j.fetch.retired", retired, 5);
    cyc(1, 0, 0, 4'd1, "j.decode");
    cyc(1, 0, 0, 4'd11, "j.jump");
    check_val("j.jump.pc_we", pc_we, 1'b1);
    check_val("j.jump.pc_src", pc_src, 2'b10);
    $display("txn j done");

    // ---------------- addi ----------------
    cyc(1, 1, 0, 4'd0, "addi.fetch");
    INST = 32'h20080005;
    check_val("addi.fetch.retired", retired, 6);
    cyc(1, 0, 0, 4'd1, "addi.decode");
    cyc(1, 0, 0, 4'd9, "addi.ex");
    check_val("addi.ex.srcb", alu_src_b, 2'b10);
    cyc(1, 0, 0, 4'd10, "addi.wb");
    check_val("addi.wb.reg_we", reg_we, 1'b1);
    check_val("addi.wb.reg_dst", reg_dst, 1'b0);
    $display("txn addi done");

    // ---------------- illegal opcode 0x3F ----------------
    cyc(1, 1, 0, 4'd0, "badop.fetch");
    INST = 32'hFC000000;
    check_val("badop.fetch.retired", retired, 7);
    cyc(1, 0, 0, 4'd1, "badop.decode");
    check_val("badop.decode.illegal", illegal, 1'b0);
    $display("txn illegal opcode done");

    // ---------------- illegal funct 0x3F ----------------
    cyc(1, 1, 0, 4'd0, "badfn.fetch");
    INST = 32'h0000003F;
    check_val("badfn.fetch.illegal", illegal, 1'b1);
    check_val("badfn.fetch.retired", retired, 7);
    cyc(1, 0, 0, 4'd1, "badfn.decode");
    cyc(1, 0, 0, 4'd6, "badfn.exec");
    $display("txn illegal funct done");

    // ---------------- reset during MEMWR wait ----------------
    cyc(1, 1, 0, 4'd0, "swrst.fetch");
    INST = 32'hAC080004;
    check_val("swrst.fetch.illegal", illegal, 1'b1);
    check_val("swrst.fetch.retired", retired, 7);
    cyc(1, 0, 0, 4'd1, "swrst.decode");
    cyc(1, 0, 0, 4'd2, "swrst.memadr");
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 4'd5, "swrst.wait");
      check_val("swrst.wait.mem_we", mem_we, 1'b1);
    end
    cyc(0, 1, 0, 4'd5, "swrst.rstlow");
    check_val("swrst.rstlow.mem_we", mem_we, 1'b0);
    check_val("swrst.rstlow.mem_req", mem_req, 1'b0);
    INST = 32'h00221820;
    cyc(1, 0, 0, 4'd0, "swrst.after");
    check_val("swrst.after.retired", retired, 0);
    check_val("swrst.after.illegal", illegal, 1'b0);
    check_val("swrst.after.mem_req", mem_req, 1'b1);
    $display("txn reset-in-memwr done");

    // ---------------- ack on the last permitted wait cycle ----------------
    // The cycle above was wait 1; 14 more, then ack in wait 16.
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 4'd0, "edge.wait");
    cyc(1, 1, 0, 4'd0, "edge.ack");
    check_val("edge.ack.bus_err", bus_err, 1'b0);
    check_val("edge.ack.ir_we", ir_we, 1'b1);
    cyc(1, 0, 0, 4'd1, "edge.decode");
    check_val("edge.decode.bus_err", bus_err, 1'b0);
    cyc(1, 0, 0, 4'd6, "edge.exec");
    cyc(1, 0, 0, 4'd7, "edge.rwb");
    $display("txn late-ack add done");

    // ---------------- timeout in FETCH ----------------
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 4'd0, "to.wait");
      check_val("to.wait.mem_req", mem_req, 1'b1);
    end
    check_val("to.wait16.bus_err", bus_err, 1'b0);
    check_val("to.wait16.retired", retired, 1);
    cyc(1, 0, 0, 4'd12, "to.halt");
    check_val("to.halt.bus_err", bus_err, 1'b1);
    check_val("to.halt.mem_req", mem_req, 1'b0);
    cyc(1, 1, 1, 4'd12, "to.halt2");
    check_val("to.halt2.mem_req", mem_req, 1'b0);
    check_val("to.halt2.pc_we", pc_we, 1'b0);
    check_val("to.halt2.ir_we", ir_we, 1'b0);
    cyc(0, 0, 0, 4'd12, "to.rstlow");
    cyc(1, 0, 0, 4'd0, "to.after");
    check_val("to.after.bus_err", bus_err, 1'b0);
    check_val("to.after.retired", retired, 0);
    $display("txn timeout done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
